// File: rtl/t_flip_flop.sv
// t_flip_flop
// -----------
// WIDTH independent toggle bits with complementary outputs. On each rising
// clk edge every bit whose toggle input is 1 inverts; bits with toggle 0 hold.
// rst is asynchronous and active-low: while it is 0 the register is forced to
// RESET_VALUE. Reset dominates any clock edge that arrives while it is low.
//
// Handshake: none. t is sampled only at the rising clk edge, so changes on t
// between edges have no effect. The new q is visible one edge later.
//
// Only q is stored. qb is the bitwise inverse of that single register, so it
// cannot disagree with q, including during reset.

module t_flip_flop #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] t,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Single state register holding the toggle bits.
    logic [WIDTH-1:0] r_q;

    // Next-state value: each bit flips where its toggle enable is set.
    logic [WIDTH-1:0] w_q_next;

    // Compute the toggled value from the current state and the toggle mask.
    always_comb begin
        w_q_next = r_q ^ t;
    end

    // State update: asynchronous reset to RESET_VALUE, otherwise load the
    // toggled value on every rising clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= w_q_next;
        end
    end

    // Both outputs come from the same register with no path from t.
    assign q  = r_q;
    assign qb = ~r_q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Bench for t_flip_flop: a WIDTH=1 default instance and a WIDTH=4 instance
// with RESET_VALUE=4'b1010 share clk and rst. Inputs change on falling edges,
// outputs are sampled on falling edges (or shortly after async reset events).

module tb_t_flip_flop;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] t1  = 1'b0;
    logic [0:0] q1, qb1;
    logic [3:0] t4  = 4'b0000;
    logic [3:0] q4, qb4;

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    t_flip_flop u_dut1 (
        .t   (t1),
        .clk (clk),
        .rst (rst),
        .q   (q1),
        .qb  (qb1)
    );

    t_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) u_dut4 (
        .t   (t4),
        .clk (clk),
        .rst (rst),
        .q   (q4),
        .qb  (qb4)
    );

    // ---------------- vector tables ----------------
    typedef struct {
        logic t;
        logic exp_q;
    } vec1_t;

    typedef struct {
        logic [3:0] t;
        logic [3:0] exp_q;
    } vec4_t;

    vec1_t v1[4];
    vec4_t v4[3];

    // ---------------- scoreboard helpers ----------------
    task automatic check1(input string name, input logic exp_q);
        n_vec++;
        if (q1 !== exp_q || qb1 !== ~exp_q) begin
            n_err++;
            $display("FAIL %s: q=%b qb=%b, required q=%b qb=%b",
                     name, q1, qb1, exp_q, ~exp_q);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] exp_q);
        n_vec++;
        if (q4 !== exp_q || qb4 !== ~exp_q) begin
            n_err++;
            $display("FAIL %s: q=%b qb=%b, required q=%b qb=%b",
                     name, q4, qb4, exp_q, ~exp_q);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        v1[0] = '{t: 1'b1, exp_q: 1'b1};
        v1[1] = '{t: 1'b0, exp_q: 1'b1};
        v1[2] = '{t: 1'b1, exp_q: 1'b0};
        v1[3] = '{t: 1'b1, exp_q: 1'b1};

        v4[0] = '{t: 4'b0110, exp_q: 4'b1100};
        v4[1] = '{t: 4'b1111, exp_q: 4'b0011};
        v4[2] = '{t: 4'b0001, exp_q: 4'b0010};

        // 1: reset at a falling edge, visible before any rising edge.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("reset_immediate_w1", 1'b0);
        check4("reset_immediate_w4", 4'b1010);
        t1 = 1'b1;
        t4 = 4'b1111;
        repeat (2) @(negedge clk);
        check1("reset_held_w1", 1'b0);
        check4("reset_held_w4", 4'b1010);

        // 2: release with t=0, then one edge: no change.
        t1  = 1'b0;
        t4  = 4'b0000;
        rst = 1'b1;
        #1;
        check1("release_no_change_w1", 1'b0);
        @(negedge clk);
        check1("hold_after_release_w1", 1'b0);
        check4("hold_after_release_w4", 4'b1010);

        // 3: toggle sequence from the table.
        for (int i = 0; i < 4; i++) begin
            t1 = v1[i].t;
            @(negedge clk);
            check1($sformatf("toggle_seq_%0d", i), v1[i].exp_q);
        end

        // 4: mid-operation reset with q=1 and t=1.
        t1  = 1'b1;
        rst = 1'b0;
        #1;
        check1("mid_reset_immediate", 1'b0);
        repeat (2) @(negedge clk);
        check1("mid_reset_no_toggle", 1'b0);
        t1  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check1("post_reset_t0", 1'b0);
        t1 = 1'b1;
        @(negedge clk);
        check1("post_reset_t1", 1'b1);

        // 5: reset halfway between rising edges while q=1.
        t1 = 1'b0;
        @(posedge clk);
        #5;
        check1("before_async_reset", 1'b1);
        rst = 1'b0;
        #1;
        check1("async_reset_between_edges", 1'b0);
        check4("async_reset_between_edges_w4", 4'b1010);

        // Glitches on t between edges are ignored.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #3 t1 = 1'b1;
        #3 t1 = 1'b0;
        @(negedge clk);
        check1("t_glitch_ignored", 1'b0);

        // 6: WIDTH=4 toggle vectors from RESET_VALUE=1010.
        check4("w4_before_toggle", 4'b1010);
        for (int i = 0; i < 3; i++) begin
            t4 = v4[i].t;
            @(negedge clk);
            check4($sformatf("w4_toggle_%0d", i), v4[i].exp_q);
        end
        t4 = 4'b0000;
        @(negedge clk);
        check4("w4_hold", 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
